// File: rtl/tetris_pkg.sv
// Shared board geometry, row/coordinate types and line-clear FSM states.
package tetris_pkg;

  localparam int unsigned BOARD_WIDTH  = 10;
  localparam int unsigned BOARD_HEIGHT = 20;
  localparam int unsigned COORD_W      = 7;
  localparam int unsigned CNT_W        = 4;
  localparam int unsigned TOTAL_W      = 16;

  typedef logic [BOARD_WIDTH-1:0] row_t;
  typedef logic [COORD_W-1:0]     coord_t;

  localparam row_t   FULL_ROW   = '1;
  localparam coord_t BOTTOM_ROW = coord_t'(BOARD_HEIGHT - 1);

  typedef enum logic [2:0] {IDLE, READ, CMP, FILL, NOTIFY, DONE} rc_state_t;

  // Running line total clamps at all-ones instead of wrapping.
  function automatic logic [TOTAL_W-1:0] sat_add(input logic [TOTAL_W-1:0] a,
                                                 input logic [CNT_W-1:0]   b);
    logic [TOTAL_W:0] s;
    s = {1'b0, a} + (TOTAL_W+1)'(b);
    return s[TOTAL_W] ? {TOTAL_W{1'b1}} : s[TOTAL_W-1:0];
  endfunction

endpackage

// File: rtl/row_clear_ctrl.sv
// Line-clear sequencer: scans upward from the locked piece, compacts non-full rows
// down through the board RAM ports, zero-fills the top and notifies the renderer.
module row_clear_ctrl
  import tetris_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        lock_valid,
  input  logic [6:0]  lock_row,
  output logic        busy,
  output logic        done,
  output logic [6:0]  board_rd_addr,
  input  logic [9:0]  board_rd_data,
  output logic        board_wr_en,
  output logic [6:0]  board_wr_addr,
  output logic [9:0]  board_wr_data,
  output logic        Clear_row,
  input  logic        clear_ack,
  output logic [6:0]  Row_to_clear,
  output logic [3:0]  Num_rows_to_clear,
  output logic [15:0] lines_total
);

  rc_state_t        state;
  coord_t           r;
  coord_t           w;
  logic [CNT_W-1:0] cnt;
  logic             first_found;

  logic             row_full;
  logic [CNT_W-1:0] cnt_inc;
  coord_t           lock_clamped;

  assign row_full     = &board_rd_data;
  assign cnt_inc      = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  assign lock_clamped = (lock_row > BOTTOM_ROW) ? BOTTOM_ROW : lock_row;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state             <= IDLE;
      r                 <= '0;
      w                 <= '0;
      cnt               <= '0;
      first_found       <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      board_rd_addr     <= '0;
      board_wr_en       <= 1'b0;
      board_wr_addr     <= '0;
      board_wr_data     <= '0;
      Clear_row         <= 1'b0;
      Row_to_clear      <= '0;
      Num_rows_to_clear <= '0;
      lines_total       <= '0;
    end else begin
      board_wr_en <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (lock_valid) begin
            r             <= lock_clamped;
            w             <= lock_clamped;
            cnt           <= '0;
            first_found   <= 1'b0;
            board_rd_addr <= lock_clamped;
            busy          <= 1'b1;
            state         <= READ;
          end
        end
        READ: state <= CMP;
        CMP: begin
          if (row_full) begin
            cnt <= cnt_inc;
            if (!first_found) begin
              Row_to_clear <= r;
              first_found  <= 1'b1;
            end
          end else begin
            // w only trails r once a full row was skipped, so the write is a real shift.
            if (w != r) begin
              board_wr_en   <= 1'b1;
              board_wr_addr <= w;
              board_wr_data <= board_rd_data;
            end
            if (w != '0) w <= w - COORD_W'(1);
          end
          if (r == '0) begin
            if (row_full || cnt != '0) begin
              state <= FILL;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end else begin
            r             <= r - COORD_W'(1);
            board_rd_addr <= r - COORD_W'(1);
            state         <= READ;
          end
        end
        FILL: begin
          board_wr_en   <= 1'b1;
          board_wr_addr <= w;
          board_wr_data <= '0;
          if (w == '0) begin
            state             <= NOTIFY;
            Clear_row         <= 1'b1;
            Num_rows_to_clear <= cnt;
            lines_total       <= sat_add(lines_total, cnt);
          end else begin
            w <= w - COORD_W'(1);
          end
        end
        NOTIFY: begin
          if (clear_ack) begin
            state     <= DONE;
            Clear_row <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_row_clear_ctrl.sv
// Self-checking bench for row_clear_ctrl with a registered-read board model and a notify scoreboard.
module tb_row_clear_ctrl;
  import tetris_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        lock_valid;
  logic [6:0]  lock_row;
  logic        busy;
  logic        done;
  logic [6:0]  board_rd_addr;
  logic [9:0]  board_rd_data;
  logic        board_wr_en;
  logic [6:0]  board_wr_addr;
  logic [9:0]  board_wr_data;
  logic        clear_row;
  logic        clear_ack;
  logic [6:0]  row_to_clear;
  logic [3:0]  num_rows;
  logic [15:0] lines_total;

  always #5 clk = ~clk;

  row_clear_ctrl dut (
    .Clk               (clk),
    .Reset             (reset),
    .lock_valid        (lock_valid),
    .lock_row          (lock_row),
    .busy              (busy),
    .done              (done),
    .board_rd_addr     (board_rd_addr),
    .board_rd_data     (board_rd_data),
    .board_wr_en       (board_wr_en),
    .board_wr_addr     (board_wr_addr),
    .board_wr_data     (board_wr_data),
    .Clear_row         (clear_row),
    .clear_ack         (clear_ack),
    .Row_to_clear      (row_to_clear),
    .Num_rows_to_clear (num_rows),
    .lines_total       (lines_total)
  );

  typedef struct {
    logic [6:0]  row;
    logic [3:0]  num;
    logic [15:0] total;
  } note_t;

  note_t       exp_q[$];
  logic [9:0]  mem      [BOARD_HEIGHT];
  logic [9:0]  load_img [BOARD_HEIGHT];
  logic [9:0]  exp_img  [BOARD_HEIGHT];
  logic        load_en;
  int          wr_count;
  int          below_viol;
  int          cur_lock = 19;
  logic [15:0] exp_total;
  int          checks;
  int          errors;

  // Board model: one-cycle registered read, bench-side bulk load while the DUT is idle.
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < BOARD_HEIGHT; i++) mem[i] <= load_img[i];
    end else if (board_wr_en) begin
      wr_count <= wr_count + 1;
      if (int'(board_wr_addr) > cur_lock) below_viol <= below_viol + 1;
      else mem[board_wr_addr] <= board_wr_data;
    end
    board_rd_data <= (int'(board_rd_addr) < BOARD_HEIGHT) ? mem[board_rd_addr] : 10'h0;
  end

  task automatic load_board();
    load_en = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic clear_img();
    for (int i = 0; i < BOARD_HEIGHT; i++) load_img[i] = 10'h0;
  endtask

  task automatic run_clear(input int lock, input int hold, input bit mid_pulse);
    int lc, dest, cnt, shifts, first, n, clr_cycles, busy_bad, wr0, viol0, bad_rows, exp_n;
    bit seen;
    note_t e;
    load_board();
    lc = (lock > BOARD_HEIGHT - 1) ? BOARD_HEIGHT - 1 : lock;
    for (int i = 0; i < BOARD_HEIGHT; i++) exp_img[i] = load_img[i];
    dest = lc; cnt = 0; shifts = 0; first = -1;
    for (int i = lc; i >= 0; i--) begin
      if (load_img[i] == FULL_ROW) begin
        cnt++;
        if (first < 0) first = i;
      end else begin
        if (dest != i) shifts++;
        exp_img[dest] = load_img[i];
        dest--;
      end
    end
    for (int i = dest; i >= 0; i--) exp_img[i] = 10'h0;
    if (cnt > 0) begin
      exp_total = ({16'h0, exp_total} + 32'(cnt) > 32'hFFFF) ? 16'hFFFF : exp_total + 16'(cnt);
      e.row = 7'(first); e.num = 4'(cnt); e.total = exp_total;
      exp_q.push_back(e);
    end
    cur_lock = lc;
    wr0 = wr_count; viol0 = below_viol;
    lock_row = 7'(lock); lock_valid = 1'b1;
    @(posedge clk); #1;
    lock_valid = 1'b0;
    n = 1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept: got %b expected 1", busy); end
    seen = 0; clr_cycles = 0; busy_bad = 0;
    while (!done && n < 400) begin
      if (clear_row) begin
        clr_cycles++;
        if (!busy) busy_bad++;
        if (!seen) begin
          seen = 1;
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL unexpected_clear_row: got Clear_row=1 expected none");
          end else begin
            e = exp_q.pop_front();
            if (row_to_clear !== e.row || num_rows !== e.num || lines_total !== e.total) begin
              errors++;
              $display("FAIL notify: got row=%0d num=%0d total=%h expected row=%0d num=%0d total=%h",
                       row_to_clear, num_rows, lines_total, e.row, e.num, e.total);
            end
          end
        end
        if (clr_cycles == hold) clear_ack = 1'b1;
      end
      if (mid_pulse && n == 6) begin lock_valid = 1'b1; lock_row = 7'd0; end
      else lock_valid = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    clear_ack = 1'b0; lock_valid = 1'b0;
    exp_n = 2 * (lc + 1) + cnt + ((cnt > 0) ? hold : 0) + 1;
    checks++;
    if (n !== exp_n || !done) begin
      errors++; $display("FAIL done_latency: got %0d (done=%b) expected %0d", n, done, exp_n);
    end
    checks++;
    if (clr_cycles !== ((cnt > 0) ? hold : 0) || busy_bad !== 0) begin
      errors++; $display("FAIL clear_hold: got %0d cycles busy_low=%0d expected %0d busy_low=0",
                         clr_cycles, busy_bad, (cnt > 0) ? hold : 0);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || clear_row !== 1'b0) begin
      errors++; $display("FAIL post_done: got busy=%b done=%b clr=%b expected 0 0 0", busy, done, clear_row);
    end
    checks++;
    if (wr_count - wr0 !== shifts + cnt || below_viol !== viol0) begin
      errors++; $display("FAIL writes: got %0d writes, %0d below-lock expected %0d writes, 0 below-lock",
                         wr_count - wr0, below_viol - viol0, shifts + cnt);
    end
    bad_rows = 0;
    for (int i = 0; i < BOARD_HEIGHT; i++) if (mem[i] !== exp_img[i]) bad_rows++;
    checks++;
    if (bad_rows != 0) begin
      errors++; $display("FAIL board: got %0d wrong rows (row19=%h row0=%h) expected 0 (row19=%h row0=%h)",
                         bad_rows, mem[19], mem[0], exp_img[19], exp_img[0]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || clear_row !== 1'b0 || board_wr_en !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got busy=%b clr=%b wr=%b done=%b expected 0", busy, clear_row, board_wr_en, done);
    end
    checks++;
    if (lines_total !== 16'h0 || num_rows !== 4'h0 || row_to_clear !== 7'h0) begin
      errors++; $display("FAIL reset_data: got total=%h num=%h row=%h expected 0", lines_total, num_rows, row_to_clear);
    end
    reset = 1'b0;
    exp_total = 16'h0;
  endtask

  task automatic test_no_clear();
    for (int i = 0; i < BOARD_HEIGHT; i++) load_img[i] = 10'($urandom_range(0, 1022));
    run_clear(19, 1, 0);
  endtask

  task automatic test_single_clear();
    clear_img();
    load_img[19] = 10'h3FF; load_img[18] = 10'h155;
    run_clear(19, 1, 0);
  endtask

  task automatic test_two_clear();
    clear_img();
    load_img[19] = 10'h3FF; load_img[18] = 10'h0F0; load_img[17] = 10'h3FF; load_img[16] = 10'h00F;
    run_clear(19, 1, 0);
  endtask

  task automatic test_ack_delay();
    clear_img();
    for (int i = 16; i < 20; i++) load_img[i] = 10'h3FF;
    load_img[15] = 10'h2A5;
    run_clear(19, 10, 1);
  endtask

  task automatic test_partial_lock();
    for (int i = 0; i < BOARD_HEIGHT; i++) load_img[i] = 10'($urandom_range(0, 1022));
    load_img[10] = 10'h3FF; load_img[8] = 10'h3FF; load_img[15] = 10'h3FF;
    run_clear(10, 2, 0);
  endtask

  task automatic test_back_to_back();
    clear_img();
    load_img[19] = 10'h3FF; load_img[18] = 10'h001;
    run_clear(100, 1, 0);
    clear_img();
    load_img[0] = 10'h3FF; load_img[1] = 10'h3FF;
    run_clear(1, 3, 0);
  endtask

  task automatic test_reset_in_fill();
    int n;
    clear_img();
    for (int i = 16; i < 20; i++) load_img[i] = 10'h3FF;
    load_board();
    cur_lock = 19;
    lock_row = 7'd19; lock_valid = 1'b1;
    @(posedge clk); #1;
    lock_valid = 1'b0;
    n = 1;
    while (n < 42) begin @(posedge clk); #1; n++; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || clear_row !== 1'b0 || board_wr_en !== 1'b0 ||
        lines_total !== 16'h0 || num_rows !== 4'h0 || row_to_clear !== 7'h0 || board_rd_addr !== 7'h0) begin
      errors++; $display("FAIL reset_in_fill: got busy=%b wr=%b clr=%b total=%h row=%h expected all 0",
                         busy, board_wr_en, clear_row, lines_total, row_to_clear);
    end
    exp_total = 16'h0;
  endtask

  task automatic test_saturation();
    force dut.lines_total = 16'hFFFE;
    @(posedge clk); #1;
    release dut.lines_total;
    exp_total = 16'hFFFE;
    clear_img();
    for (int i = 16; i < 20; i++) load_img[i] = 10'h3FF;
    run_clear(19, 1, 0);
    clear_img();
    load_img[19] = 10'h3FF;
    run_clear(19, 1, 0);
  endtask

  initial begin
    reset = 1'b1; lock_valid = 1'b0; lock_row = 7'd0; clear_ack = 1'b0; load_en = 1'b0;
    checks = 0; errors = 0; exp_total = 16'h0;
    clear_img();
    test_reset();
    test_no_clear();
    test_single_clear();
    test_two_clear();
    test_ack_delay();
    test_partial_lock();
    test_back_to_back();
    test_reset_in_fill();
    test_saturation();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending notifies expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
